// File: rtl/secuencia_lectura_rtc_pkg.sv
// Shared constants for the RTC access path: register addresses and the read-sweep FSM encoding.
// The address constants are also used by the write-address block.
package secuencia_lectura_rtc_pkg;

    localparam logic [7:0] DIR_SEG     = 8'h21;
    localparam logic [7:0] DIR_MIN     = 8'h22;
    localparam logic [7:0] DIR_HORA    = 8'h23;
    localparam logic [7:0] DIR_DIA     = 8'h24;
    localparam logic [7:0] DIR_MES     = 8'h25;
    localparam logic [7:0] DIR_YEAR    = 8'h26;
    localparam logic [7:0] DIR_CR_SEG  = 8'h41;
    localparam logic [7:0] DIR_CR_MIN  = 8'h42;
    localparam logic [7:0] DIR_CR_HORA = 8'h43;

    localparam int         N_REGS        = 9;
    localparam logic [3:0] INDICE_ULTIMO = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEDIR,
        ST_ESPERA_DONE,
        ST_SIGUIENTE,
        ST_COMMIT,
        ST_PAUSA
    } estado_t;

endpackage

// File: rtl/secuencia_lectura_rtc_tabla_dir_lectura.sv
// Combinational ROM mapping the sweep index to the RTC register address.
// Indexes past the last register return 8'h00.
module tabla_dir_lectura
    import secuencia_lectura_rtc_pkg::*;
(
    input  logic [3:0] indice,
    output logic [7:0] direccion
);

    always_comb begin
        case (indice)
            4'd0:    direccion = DIR_SEG;
            4'd1:    direccion = DIR_MIN;
            4'd2:    direccion = DIR_HORA;
            4'd3:    direccion = DIR_DIA;
            4'd4:    direccion = DIR_MES;
            4'd5:    direccion = DIR_YEAR;
            4'd6:    direccion = DIR_CR_SEG;
            4'd7:    direccion = DIR_CR_MIN;
            4'd8:    direccion = DIR_CR_HORA;
            default: direccion = 8'h00;
        endcase
    end

endmodule

// File: rtl/secuencia_lectura_rtc.sv
// Periodic read sweep of the nine RTC time/date/timer registers through the bus driver.
// Bytes land in a shadow bank and reach the outputs only when a whole sweep completes cleanly.
module secuencia_lectura_rtc
    import secuencia_lectura_rtc_pkg::*;
#(
    parameter int PERIODO = 1000,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en_lectura,
    input  logic       escribiendo,
    input  logic       rd_done,
    input  logic [7:0] dato_in,
    output logic       rd_req,
    output logic [7:0] direccion,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] year,
    output logic [7:0] cr_seg,
    output logic [7:0] cr_min,
    output logic [7:0] cr_hora,
    output logic       barrido_listo,
    output logic       ocupado,
    output logic       error_lectura
);

    localparam logic [CNT_W-1:0] LIM_TIMEOUT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LIM_PERIODO = CNT_W'(PERIODO - 1);

    estado_t          estado_q,    estado_d;
    logic [3:0]       indice_q,    indice_d;
    logic [CNT_W-1:0] contador_q,  contador_d;
    logic             rd_req_q,    rd_req_d;
    logic [7:0]       direccion_q, direccion_d;
    logic             barrido_q,   barrido_d;
    logic             ocupado_q,   ocupado_d;
    logic             error_q,     error_d;
    logic [7:0]       shadow_q [N_REGS];
    logic [7:0]       shadow_d [N_REGS];
    logic [7:0]       salida_q [N_REGS];
    logic [7:0]       salida_d [N_REGS];
    logic [7:0]       dir_tabla;

    tabla_dir_lectura u_tabla (
        .indice    (indice_q),
        .direccion (dir_tabla)
    );

    always_comb begin
        estado_d    = estado_q;
        indice_d    = indice_q;
        contador_d  = contador_q;
        rd_req_d    = rd_req_q;
        direccion_d = direccion_q;
        barrido_d   = 1'b0;
        error_d     = error_q;
        shadow_d    = shadow_q;
        salida_d    = salida_q;

        case (estado_q)
            ST_IDLE: begin
                contador_d = '0;
                if (en_lectura && !escribiendo) begin
                    estado_d = ST_PEDIR;
                    indice_d = 4'd0;
                    for (int i = 0; i < N_REGS; i++) begin
                        shadow_d[i] = 8'h00;
                    end
                end
            end
            ST_PEDIR: begin
                rd_req_d    = 1'b1;
                direccion_d = dir_tabla;
                contador_d  = '0;
                estado_d    = ST_ESPERA_DONE;
            end
            // A done arriving on the timeout cycle still counts as a good read.
            ST_ESPERA_DONE: begin
                if (rd_done) begin
                    for (int i = 0; i < N_REGS; i++) begin
                        if (indice_q == 4'(i)) begin
                            shadow_d[i] = dato_in;
                        end
                    end
                    rd_req_d = 1'b0;
                    estado_d = ST_SIGUIENTE;
                end else if (contador_q == LIM_TIMEOUT) begin
                    rd_req_d   = 1'b0;
                    error_d    = 1'b1;
                    contador_d = '0;
                    estado_d   = ST_PAUSA;
                end else begin
                    contador_d = contador_q + 1'b1;
                end
            end
            ST_SIGUIENTE: begin
                if (!en_lectura || escribiendo) begin
                    estado_d = ST_IDLE;
                end else if (indice_q == INDICE_ULTIMO) begin
                    estado_d = ST_COMMIT;
                end else begin
                    indice_d = indice_q + 4'd1;
                    estado_d = ST_PEDIR;
                end
            end
            ST_COMMIT: begin
                salida_d   = shadow_q;
                error_d    = 1'b0;
                barrido_d  = 1'b1;
                contador_d = '0;
                estado_d   = ST_PAUSA;
            end
            ST_PAUSA: begin
                if (contador_q == LIM_PERIODO) begin
                    contador_d = '0;
                    estado_d   = ST_IDLE;
                end else begin
                    contador_d = contador_q + 1'b1;
                end
            end
            default: begin
                estado_d = ST_IDLE;
            end
        endcase

        ocupado_d = (estado_d == ST_PEDIR) || (estado_d == ST_ESPERA_DONE) ||
                    (estado_d == ST_SIGUIENTE) || (estado_d == ST_COMMIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q    <= ST_IDLE;
            indice_q    <= 4'd0;
            contador_q  <= '0;
            rd_req_q    <= 1'b0;
            direccion_q <= 8'h00;
            barrido_q   <= 1'b0;
            ocupado_q   <= 1'b0;
            error_q     <= 1'b0;
            for (int i = 0; i < N_REGS; i++) begin
                shadow_q[i] <= 8'h00;
                salida_q[i] <= 8'h00;
            end
        end else begin
            estado_q    <= estado_d;
            indice_q    <= indice_d;
            contador_q  <= contador_d;
            rd_req_q    <= rd_req_d;
            direccion_q <= direccion_d;
            barrido_q   <= barrido_d;
            ocupado_q   <= ocupado_d;
            error_q     <= error_d;
            shadow_q    <= shadow_d;
            salida_q    <= salida_d;
        end
    end

    assign rd_req        = rd_req_q;
    assign direccion     = direccion_q;
    assign barrido_listo = barrido_q;
    assign ocupado       = ocupado_q;
    assign error_lectura = error_q;
    assign seg           = salida_q[0];
    assign min           = salida_q[1];
    assign hora          = salida_q[2];
    assign dia           = salida_q[3];
    assign mes           = salida_q[4];
    assign year          = salida_q[5];
    assign cr_seg        = salida_q[6];
    assign cr_min        = salida_q[7];
    assign cr_hora       = salida_q[8];

endmodule

// File: tb/tb_secuencia_lectura_rtc.sv
// Directed bench for secuencia_lectura_rtc with a small in-line bus driver model.
// The model answers each read after a fixed latency with data = address ^ bus_xor.
module tb_secuencia_lectura_rtc;
    import secuencia_lectura_rtc_pkg::*;

    localparam int PERIODO = 8;
    localparam int TIMEOUT = 6;
    localparam int CNT_W   = 16;
    localparam int BUS_LAT = 3;
    localparam int BUDGET  = 400;

    logic       clk;
    logic       reset_n;
    logic       en_lectura;
    logic       escribiendo;
    logic       rd_done;
    logic [7:0] dato_in;
    logic       rd_req;
    logic [7:0] direccion;
    logic [7:0] seg, min, hora, dia, mes, year, cr_seg, cr_min, cr_hora;
    logic       barrido_listo;
    logic       ocupado;
    logic       error_lectura;
    logic [71:0] outs_all;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] bus_xor   = 8'hFF;
    logic [7:0] drop_addr = 8'h00;
    logic [7:0] slow_addr = 8'h00;
    int         slow_lat  = BUS_LAT;
    logic [7:0] cur_addr  = 8'h00;
    bit         serving   = 1'b0;
    int         bus_cnt   = 0;
    int         req_cnt   = 0;
    logic [7:0] req_log [16];
    int         n_barrido = 0;

    secuencia_lectura_rtc #(
        .PERIODO (PERIODO),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en_lectura    (en_lectura),
        .escribiendo   (escribiendo),
        .rd_done       (rd_done),
        .dato_in       (dato_in),
        .rd_req        (rd_req),
        .direccion     (direccion),
        .seg           (seg),
        .min           (min),
        .hora          (hora),
        .dia           (dia),
        .mes           (mes),
        .year          (year),
        .cr_seg        (cr_seg),
        .cr_min        (cr_min),
        .cr_hora       (cr_hora),
        .barrido_listo (barrido_listo),
        .ocupado       (ocupado),
        .error_lectura (error_lectura)
    );

    assign outs_all = {seg, min, hora, dia, mes, year, cr_seg, cr_min, cr_hora};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dir_de(input int i);
        case (i)
            0: dir_de = 8'h21;
            1: dir_de = 8'h22;
            2: dir_de = 8'h23;
            3: dir_de = 8'h24;
            4: dir_de = 8'h25;
            5: dir_de = 8'h26;
            6: dir_de = 8'h41;
            7: dir_de = 8'h42;
            default: dir_de = 8'h43;
        endcase
    endfunction

    // Expected committed bank for a clean sweep served with the given data mask, seg in the MSBs.
    function automatic logic [71:0] esperado(input logic [7:0] x);
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            r = {r[63:0], dir_de(i) ^ x};
        end
        return r;
    endfunction

    // One clock cycle: sample at the falling edge, then advance the bus driver model.
    task automatic tick();
        int lat;
        @(negedge clk);
        if (barrido_listo) n_barrido++;
        rd_done = 1'b0;
        if (serving && !rd_req) serving = 1'b0;
        if (!serving && rd_req) begin
            serving  = 1'b1;
            bus_cnt  = 0;
            cur_addr = direccion;
            if (req_cnt < 16) req_log[req_cnt] = direccion;
            req_cnt++;
        end
        if (serving) begin
            lat = (cur_addr == slow_addr) ? slow_lat : BUS_LAT;
            bus_cnt++;
            if (bus_cnt >= lat && cur_addr != drop_addr) begin
                rd_done = 1'b1;
                dato_in = cur_addr ^ bus_xor;
                serving = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        en_lectura  = 1'b0;
        escribiendo = 1'b0;
        rd_done     = 1'b0;
        dato_in     = 8'h00;
        repeat (2) tick();
        n_vec++;
        if (outs_all !== 72'h0) begin
            n_err++; $display("[TB] FAIL reset_outs: got %h expected 0", outs_all);
        end
        n_vec++;
        if ({rd_req, direccion} !== 9'h000) begin
            n_err++; $display("[TB] FAIL reset_req_dir: got %b/%h expected 0/00", rd_req, direccion);
        end
        n_vec++;
        if ({barrido_listo, ocupado, error_lectura} !== 3'b000) begin
            n_err++; $display("[TB] FAIL reset_flags: got %b expected 000", {barrido_listo, ocupado, error_lectura});
        end
        reset_n = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({rd_req, ocupado} !== 2'b00) begin
            n_err++; $display("[TB] FAIL idle_disabled: got %b expected 00", {rd_req, ocupado});
        end
    endtask

    task automatic test_clean_sweep();
        bit found = 1'b0;
        bit orden_ok = 1'b1;
        req_cnt    = 0;
        n_barrido  = 0;
        bus_xor    = 8'hFF;
        en_lectura = 1'b1;
        for (int c = 0; c < BUDGET && !found; c++) begin
            tick();
            if (barrido_listo) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++; $display("[TB] FAIL sweep1_done: got no barrido_listo expected pulse");
        end
        n_vec++;
        if (req_cnt != 9) begin
            n_err++; $display("[TB] FAIL sweep1_req_count: got %0d expected 9", req_cnt);
        end
        for (int i = 0; i < 9 && i < req_cnt; i++) begin
            if (req_log[i] !== dir_de(i)) orden_ok = 1'b0;
        end
        n_vec++;
        if (!orden_ok) begin
            n_err++; $display("[TB] FAIL sweep1_order: got first %h last %h expected 21..43", req_log[0], req_log[8]);
        end
        n_vec++;
        if (seg !== 8'hDE || cr_hora !== 8'hBC) begin
            n_err++; $display("[TB] FAIL sweep1_seg_crhora: got %h/%h expected DE/BC", seg, cr_hora);
        end
        n_vec++;
        if (outs_all !== esperado(8'hFF)) begin
            n_err++; $display("[TB] FAIL sweep1_bank: got %h expected %h", outs_all, esperado(8'hFF));
        end
        tick();
        n_vec++;
        if (barrido_listo !== 1'b0 || n_barrido != 1) begin
            n_err++; $display("[TB] FAIL sweep1_pulse: got level %b count %0d expected 0 and 1", barrido_listo, n_barrido);
        end
    endtask

    task automatic test_hold_until_commit();
        bit found = 1'b0;
        bus_xor = 8'h5A;
        for (int c = 0; c < BUDGET && !found; c++) begin
            tick();
            if (barrido_listo) begin
                found = 1'b1;
            end else begin
                n_vec++;
                if (outs_all !== esperado(8'hFF)) begin
                    n_err++; $display("[TB] FAIL hold_cycle%0d: got %h expected %h", c, outs_all, esperado(8'hFF));
                end
            end
        end
        n_vec++;
        if (!found) begin
            n_err++; $display("[TB] FAIL sweep2_done: got no barrido_listo expected pulse");
        end
        n_vec++;
        if (outs_all !== esperado(8'h5A)) begin
            n_err++; $display("[TB] FAIL sweep2_bank: got %h expected %h", outs_all, esperado(8'h5A));
        end
    endtask

    task automatic test_timeout();
        int  cnt24 = 0;
        bit  found = 1'b0;
        int  pulsos;
        bus_xor   = 8'h11;
        drop_addr = 8'h24;
        pulsos    = n_barrido;
        for (int c = 0; c < BUDGET && !found; c++) begin
            tick();
            if (rd_req && direccion == 8'h24) cnt24++;
            if (error_lectura) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++; $display("[TB] FAIL timeout_error: got error_lectura 0 expected 1");
        end
        n_vec++;
        if (cnt24 != TIMEOUT) begin
            n_err++; $display("[TB] FAIL timeout_len: got %0d cycles expected %0d", cnt24, TIMEOUT);
        end
        n_vec++;
        if (rd_req !== 1'b0) begin
            n_err++; $display("[TB] FAIL timeout_req_drop: got %b expected 0", rd_req);
        end
        repeat (PERIODO / 2) tick();
        n_vec++;
        if (error_lectura !== 1'b1 || outs_all !== esperado(8'h5A) || n_barrido != pulsos) begin
            n_err++; $display("[TB] FAIL timeout_no_commit: got err %b bank %h pulses %0d expected 1 %h %0d",
                              error_lectura, outs_all, n_barrido - pulsos, esperado(8'h5A), 0);
        end
        drop_addr = 8'h00;
        bus_xor   = 8'hFF;
        found     = 1'b0;
        for (int c = 0; c < BUDGET && !found; c++) begin
            tick();
            if (barrido_listo) found = 1'b1;
        end
        n_vec++;
        if (!found || error_lectura !== 1'b0 || outs_all !== esperado(8'hFF)) begin
            n_err++; $display("[TB] FAIL timeout_recover: got done %b err %b bank %h expected 1 0 %h",
                              found, error_lectura, outs_all, esperado(8'hFF));
        end
    endtask

    task automatic test_escribiendo_abort();
        bit found = 1'b0;
        bit vio23 = 1'b0;
        int cnt22 = 0;
        int pulsos;
        bus_xor = 8'h33;
        pulsos  = n_barrido;
        for (int c = 0; c < BUDGET && !found; c++) begin
            tick();
            if (rd_req && direccion == 8'h22) found = 1'b1;
        end
        cnt22       = 1;
        escribiendo = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rd_req && direccion == 8'h22) cnt22++;
            if (rd_req && direccion == 8'h23) vio23 = 1'b1;
        end
        n_vec++;
        if (!found || cnt22 != BUS_LAT) begin
            n_err++; $display("[TB] FAIL wr_inflight_read: got seen %b cycles %0d expected 1 %0d", found, cnt22, BUS_LAT);
        end
        n_vec++;
        if (vio23 || rd_req !== 1'b0 || ocupado !== 1'b0) begin
            n_err++; $display("[TB] FAIL wr_abort_idle: got req23 %b req %b busy %b expected 0 0 0", vio23, rd_req, ocupado);
        end
        n_vec++;
        if (outs_all !== esperado(8'hFF) || n_barrido != pulsos || error_lectura !== 1'b0) begin
            n_err++; $display("[TB] FAIL wr_no_commit: got bank %h pulses %0d err %b expected %h 0 0",
                              outs_all, n_barrido - pulsos, error_lectura, esperado(8'hFF));
        end
        req_cnt     = 0;
        escribiendo = 1'b0;
        found       = 1'b0;
        for (int c = 0; c < BUDGET && !found; c++) begin
            tick();
            if (barrido_listo) found = 1'b1;
        end
        n_vec++;
        if (req_cnt < 1 || req_log[0] !== 8'h21) begin
            n_err++; $display("[TB] FAIL wr_restart_addr: got %h (count %0d) expected 21", req_log[0], req_cnt);
        end
        n_vec++;
        if (!found || seg !== 8'h12 || cr_hora !== 8'h70) begin
            n_err++; $display("[TB] FAIL wr_restart_commit: got done %b seg %h crh %h expected 1 12 70", found, seg, cr_hora);
        end
    endtask

    task automatic test_done_at_limit();
        bit found = 1'b0;
        int cnt25 = 0;
        int pulsos;
        bus_xor   = 8'hFF;
        slow_addr = 8'h25;
        slow_lat  = TIMEOUT;
        for (int c = 0; c < BUDGET && !found; c++) begin
            tick();
            if (rd_req && direccion == 8'h25) cnt25++;
            if (barrido_listo || error_lectura) found = 1'b1;
        end
        n_vec++;
        if (!barrido_listo || error_lectura !== 1'b0) begin
            n_err++; $display("[TB] FAIL limit_no_error: got done %b err %b expected 1 0", barrido_listo, error_lectura);
        end
        n_vec++;
        if (cnt25 != TIMEOUT || mes !== 8'hDA) begin
            n_err++; $display("[TB] FAIL limit_data: got cycles %0d mes %h expected %0d DA", cnt25, mes, TIMEOUT);
        end
        slow_addr  = 8'h00;
        en_lectura = 1'b0;
        repeat (PERIODO + 4) tick();
        pulsos  = n_barrido;
        dato_in = 8'h99;
        rd_done = 1'b1;
        repeat (4) tick();
        n_vec++;
        if (rd_req !== 1'b0 || ocupado !== 1'b0 || dut.estado_q !== ST_IDLE) begin
            n_err++; $display("[TB] FAIL spurious_state: got req %b busy %b state %0d expected 0 0 %0d",
                              rd_req, ocupado, dut.estado_q, ST_IDLE);
        end
        n_vec++;
        if (outs_all !== esperado(8'hFF) || n_barrido != pulsos || error_lectura !== 1'b0) begin
            n_err++; $display("[TB] FAIL spurious_outs: got bank %h pulses %0d err %b expected %h 0 0",
                              outs_all, n_barrido - pulsos, error_lectura, esperado(8'hFF));
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit found = 1'b0;
        en_lectura = 1'b1;
        for (int c = 0; c < BUDGET && !found; c++) begin
            tick();
            if (rd_req && direccion == 8'h41) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++; $display("[TB] FAIL midreset_reach41: got no request to 41 expected one");
        end
        reset_n    = 1'b0;
        en_lectura = 1'b0;
        #1;
        n_vec++;
        if (rd_req !== 1'b0 || direccion !== 8'h00 || outs_all !== 72'h0) begin
            n_err++; $display("[TB] FAIL midreset_outs: got req %b dir %h bank %h expected 0 00 0", rd_req, direccion, outs_all);
        end
        n_vec++;
        if (ocupado !== 1'b0 || error_lectura !== 1'b0 || dut.estado_q !== ST_IDLE) begin
            n_err++; $display("[TB] FAIL midreset_state: got busy %b err %b state %0d expected 0 0 %0d",
                              ocupado, error_lectura, dut.estado_q, ST_IDLE);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        n_vec++;
        if (rd_req !== 1'b0 || ocupado !== 1'b0) begin
            n_err++; $display("[TB] FAIL midreset_release: got req %b busy %b expected 0 0", rd_req, ocupado);
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_hold_until_commit();
        test_timeout();
        test_escribiendo_abort();
        test_done_at_limit();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
